// File: rtl/stage_fetch.sv
// ---------------------------------------------------------------------------
// stage_fetch
//
// Instruction-fetch stage of the TinyCPU pipeline. It owns the program
// counter and issues one instruction-memory request at a time. The fetched
// word is held for decode until decode takes it. The block also handles
// control-flow redirects, including squashing a response that is already
// in flight.
//
// Parameters:
//   RESET_PC            - PC loaded on reset (must be word aligned)
//
// Ports:
//   clk                 - single clock, all state changes on rising edge
//   rst                 - asynchronous active-high reset
//   stall               - decode is not consuming the held word this cycle
//   redirect_valid      - branch/jump taken, refetch from redirect_pc
//   redirect_pc         - redirect target, bits [1:0] ignored
//   imem_req_valid      - fetch request valid (only in REQ)
//   imem_req_addr       - byte address of requested word (always fetch_pc)
//   imem_req_ready      - memory accepts the request this cycle
//   imem_resp_valid     - response word valid (one per accepted request)
//   imem_resp_data      - response word
//   current_instruction - word for decode, 0 (NOP) when fetch_valid is 0
//   fetch_pc            - PC of the outstanding request or held word
//   fetch_valid         - current_instruction is a real fetched word
//
// Every output is a direct function of registered state, so there is no
// combinational path from any input to any output.
// ---------------------------------------------------------------------------
module stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] current_instruction,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid
);

  // IDLE : after reset, no request issued
  // REQ  : request presented, waiting for memory to accept it
  // WAIT : request accepted, waiting for its single response
  // HOLD : fetched word presented to decode until consumed or dropped
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        squash_q, squash_d;

  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  // The low two bits of the redirect target are forced to zero so the PC
  // can never become misaligned.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign pc_plus4            = pc_q + 32'd4;

  // State and datapath registers. Reset is asynchronous, so a reset in the
  // middle of a request or wait returns to IDLE immediately; any response
  // that arrives later is ignored because IDLE/REQ never look at it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
      squash_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      squash_q     <= squash_d;
    end
  end

  // Next-state logic. A redirect outranks both stall and the normal
  // advance. Whenever a redirect hits while a request is (or is becoming)
  // outstanding, the response cannot be cancelled at memory, so the squash
  // flag marks it to be thrown away when it eventually arrives.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    squash_d     = squash_q;

    unique case (state_q)
      ST_IDLE: begin
        // Redirects are ignored here; fetching starts at the reset PC.
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (imem_req_ready) begin
          state_d = ST_WAIT;
        end
        if (redirect_valid) begin
          pc_d         = redirect_target;
          inst_valid_d = 1'b0;
          // The old address was accepted on this edge, so its response
          // belongs to the wrong path.
          if (imem_req_ready) begin
            squash_d = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d         = redirect_target;
          inst_valid_d = 1'b0;
          if (imem_resp_valid) begin
            // Response arrived on the redirect edge: drop it and refetch.
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            inst_d       = imem_resp_data;
            inst_valid_d = 1'b1;
            state_d      = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          // Held word is dropped without being consumed, so no +4.
          pc_d         = redirect_target;
          inst_valid_d = 1'b0;
          state_d      = ST_REQ;
        end else if (!stall) begin
          // Decode captures the word on this edge.
          pc_d         = pc_plus4;
          inst_valid_d = 1'b0;
          state_d      = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs come straight from the registers.
  always_comb begin
    imem_req_valid      = (state_q == ST_REQ);
    imem_req_addr       = pc_q;
    fetch_pc            = pc_q;
    fetch_valid         = inst_valid_q;
    current_instruction = inst_valid_q ? inst_q : 32'h0;
  end

endmodule

// File: tb/tb_stage_fetch.sv
// ---------------------------------------------------------------------------
// tb_stage_fetch
//
// Self-checking bench for stage_fetch. A directed sequence walks through the
// main fetch scenarios, then a randomized phase drives stall, redirects,
// memory readiness and response latency from $urandom. Expected outputs come
// from a transaction-level model of the fetch stage: the architectural next
// PC, whether one request is outstanding (and whether its data will be
// kept), and whether a word is being held for decode.
// ---------------------------------------------------------------------------
module tb_stage_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] current_instruction;
  logic [31:0] fetch_pc;
  logic        fetch_valid;

  int checkCount;
  int errorCount;

  // Reference model state
  logic        mStarting;
  logic [31:0] mPc;
  logic        mOutstanding;
  logic        mKeep;
  logic        mHeld;
  logic [31:0] mWord;

  stage_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .imem_req_valid      (imem_req_valid),
    .imem_req_addr       (imem_req_addr),
    .imem_req_ready      (imem_req_ready),
    .imem_resp_valid     (imem_resp_valid),
    .imem_resp_data      (imem_resp_data),
    .current_instruction (current_instruction),
    .fetch_pc            (fetch_pc),
    .fetch_valid         (fetch_valid)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mStarting    = 1'b1;
    mPc          = RESET_PC;
    mOutstanding = 1'b0;
    mKeep        = 1'b0;
    mHeld        = 1'b0;
    mWord        = 32'h0;
  endtask

  // Whether the stage should be asking memory for a word right now.
  function automatic logic modelWantsReq();
    return !mStarting && !mOutstanding && !mHeld;
  endfunction

  // Advance the model by one clock edge using the inputs seen on that edge.
  task automatic modelStep(input logic st, input logic rv, input logic [31:0] rpc,
                           input logic rdy, input logic respv, input logic [31:0] rdata);
    logic [31:0] target;
    target = rpc & 32'hFFFF_FFFC;
    if (mStarting) begin
      mStarting = 1'b0;
    end else if (mOutstanding) begin
      if (respv) begin
        mOutstanding = 1'b0;
        if (mKeep && !rv) begin
          mHeld = 1'b1;
          mWord = rdata;
        end
      end
      if (rv) begin
        mKeep = 1'b0;
        mPc   = target;
      end
    end else if (mHeld) begin
      if (rv) begin
        mHeld = 1'b0;
        mPc   = target;
      end else if (!st) begin
        mHeld = 1'b0;
        mPc   = mPc + 32'd4;
      end
    end else begin
      if (rdy) begin
        mOutstanding = 1'b1;
        mKeep        = !rv;
      end
      if (rv) begin
        mPc = target;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("req_valid", {31'h0, imem_req_valid}, {31'h0, modelWantsReq()});
    checkOutput("req_addr", imem_req_addr, mPc);
    checkOutput("fetch_pc", fetch_pc, mPc);
    checkOutput("fetch_valid", {31'h0, fetch_valid}, {31'h0, mHeld});
    checkOutput("cur_instr", current_instruction, mHeld ? mWord : 32'h0);
  endtask

  // Drive one cycle of inputs (called at a falling edge), let the rising
  // edge happen, update the model, and compare at the next falling edge.
  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic respv, input logic [31:0] rdata);
    stall           = st;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    imem_req_ready  = rdy;
    imem_resp_valid = respv;
    imem_resp_data  = rdata;
    @(posedge clk);
    modelStep(st, rv, rpc, rdy, respv, rdata);
    @(negedge clk);
    compareAll();
  endtask

  // Assert reset asynchronously between edges and check it takes effect
  // immediately; release it on the next falling edge.
  task automatic pulseReset();
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    checkOutput("rst_fetch_valid", {31'h0, fetch_valid}, 32'h0);
    checkOutput("rst_cur_instr", current_instruction, 32'h0);
    checkOutput("rst_fetch_pc", fetch_pc, RESET_PC);
    @(negedge clk);
    rst = 1'b0;
    compareAll();
  endtask

  // One fetch with immediate acceptance and a one-cycle response, leaving
  // the stage in HOLD.
  task automatic fetchWord(input logic [31:0] word);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, word);
  endtask

  initial begin
    logic st;
    logic rv;
    logic rdy;
    logic respv;
    logic [31:0] rpc;
    logic [31:0] rdata;

    checkCount      = 0;
    errorCount      = 0;
    rst             = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    modelReset();

    repeat (2) @(negedge clk);
    compareAll();
    rst = 1'b0;
    compareAll();

    // Leave IDLE, then fetch 0x11, 0x22, 0x33 with zero-wait memory.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("tp1_addr0", imem_req_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("tp1_gap", current_instruction, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h11);
    checkOutput("tp1_word0", current_instruction, 32'h11);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("tp1_addr1", imem_req_addr, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h22);
    checkOutput("tp1_word1", current_instruction, 32'h22);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("tp1_addr2", imem_req_addr, 32'h8);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h33);
    checkOutput("tp1_word2", current_instruction, 32'h33);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Stall for four cycles in HOLD at PC 0xC.
    fetchWord(32'hABCD_1234);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("tp2_hold_word", current_instruction, 32'hABCD_1234);
      checkOutput("tp2_hold_pc", fetch_pc, 32'hC);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("tp2_advance", imem_req_addr, 32'h10);

    // Move back to PC 8, then redirect on the accepting edge.
    applyStimulus(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    checkOutput("tp3_pc8", imem_req_addr, 32'h8);
    applyStimulus(1'b0, 1'b1, 32'h103, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD);
    checkOutput("tp3_squashed", {31'h0, fetch_valid}, 32'h0);
    checkOutput("tp3_new_addr", imem_req_addr, 32'h100);

    // Redirect while stalled in HOLD drops the word.
    fetchWord(32'h5555_AAAA);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    checkOutput("tp4_dropped", current_instruction, 32'h0);
    checkOutput("tp4_addr", imem_req_addr, 32'h40);

    // Backpressure at the top of the address space, then wrap.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("tp5_held_addr", imem_req_addr, 32'hFFFF_FFFC);
      checkOutput("tp5_held_valid", {31'h0, imem_req_valid}, 32'h1);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7777);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("tp5_wrap", imem_req_addr, 32'h0);

    // Reset during WAIT, stray response two cycles after release.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    pulseReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0);
    checkOutput("tp6_stray", {31'h0, fetch_valid}, 32'h0);
    checkOutput("tp6_addr", imem_req_addr, RESET_PC);

    // Randomized phase: responses only while a request is outstanding,
    // plus occasional stray responses where they are ignored.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 400 == 399) begin
        pulseReset();
      end else begin
        st    = ($urandom_range(0, 2) == 0);
        rv    = ($urandom_range(0, 9) == 0);
        rpc   = $urandom;
        rdy   = ($urandom_range(0, 2) != 0);
        rdata = $urandom;
        if (mOutstanding)
          respv = ($urandom_range(0, 2) == 0);
        else if (mHeld || mStarting)
          respv = ($urandom_range(0, 15) == 0);
        else
          respv = 1'b0;
        applyStimulus(st, rv, rpc, rdy, respv, rdata);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
